// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable 50%-duty clock divider.
// A new divisor written while running takes effect only at a period boundary,
// and a stop request always lets the current high phase finish first.
// Optional feature: define CLK_DIV_CTRL_PERIOD_CNT_EN to add the 32-bit
// period_cnt output, which counts out_tick pulses.

module clk_div_ctrl #(
    parameter int C_DIV_WIDTH   = 16,
    parameter int C_DEFAULT_DIV = 16
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   enable,
    input  logic [C_DIV_WIDTH-1:0] cfg_div,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    output logic                   out_clk,
    output logic                   out_tick,
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    output logic [31:0]            period_cnt,
`endif
    output logic                   busy
);

    // Half-period reload value: bit 0 of the divisor is dropped, and anything
    // below 2 is treated as 2, so H = div/2 - 1 never underflows.
    function automatic logic [C_DIV_WIDTH-1:0] half_cnt(input logic [C_DIV_WIDTH-1:0] d);
        logic [C_DIV_WIDTH-1:0] h;
        h = d >> 1;
        if (h == '0) h = {{(C_DIV_WIDTH-1){1'b0}}, 1'b1};
        return h - 1'b1;
    endfunction

    localparam logic [C_DIV_WIDTH-1:0] DEF_H = half_cnt(C_DIV_WIDTH'(C_DEFAULT_DIV));

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PEND, S_STOP} state_t;

    state_t                 state_q, state_d;
    logic [C_DIV_WIDTH-1:0] cnt_q, cnt_d;
    // pend_h mirrors act_h whenever no update is pending, so applying it
    // unconditionally on IDLE entry is harmless.
    logic [C_DIV_WIDTH-1:0] act_h_q, act_h_d;
    logic [C_DIV_WIDTH-1:0] pend_h_q, pend_h_d;
    logic                   clk_q, clk_d;
    logic                   tick_q, tick_d;

    logic                   xfer;
    logic                   at_zero;
    logic [C_DIV_WIDTH-1:0] cfg_h;

    assign cfg_ready = aresetn && ((state_q == S_IDLE) || (state_q == S_RUN));
    assign busy      = (state_q != S_IDLE);
    assign out_clk   = clk_q;
    assign out_tick  = tick_q;
    assign xfer      = cfg_valid && cfg_ready;
    assign at_zero   = (cnt_q == '0);
    assign cfg_h     = half_cnt(cfg_div);

    // State and datapath registers; reset discards the running period and any pending divisor
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= DEF_H;
            act_h_q  <= DEF_H;
            pend_h_q <= DEF_H;
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            act_h_q  <= act_h_d;
            pend_h_q <= pend_h_d;
            clk_q    <= clk_d;
            tick_q   <= tick_d;
        end
    end

    // Next-state, counter and divisor update logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        act_h_d  = act_h_q;
        pend_h_d = pend_h_q;
        clk_d    = clk_q;
        tick_d   = 1'b0;

        // Shared half-period counter for every running state
        if (state_q != S_IDLE) begin
            if (at_zero) begin
                cnt_d  = act_h_q;
                clk_d  = ~clk_q;
                tick_d = ~clk_q;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                clk_d = 1'b0;
                cnt_d = act_h_q;
                if (xfer) begin
                    act_h_d  = cfg_h;
                    pend_h_d = cfg_h;
                    cnt_d    = cfg_h;
                end
                if (enable) state_d = S_RUN;
            end
            S_RUN: begin
                if (xfer) pend_h_d = cfg_h;
                if (!enable)   state_d = S_STOP;
                else if (xfer) state_d = S_PEND;
            end
            S_PEND: begin
                if (!enable) begin
                    state_d = S_STOP;
                end else if (at_zero && clk_q) begin
                    // Falling edge is the period boundary: swap divisors here
                    cnt_d   = pend_h_q;
                    act_h_d = pend_h_q;
                    state_d = S_RUN;
                end
            end
            S_STOP: begin
                // Low and freshly reloaded means the last high phase is complete
                if (!clk_q && (cnt_q == act_h_q)) begin
                    state_d = S_IDLE;
                    clk_d   = 1'b0;
                    tick_d  = 1'b0;
                    cnt_d   = pend_h_q;
                    act_h_d = pend_h_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    // Free-running count of completed out_tick pulses, wraps naturally
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)    period_cnt <= 32'd0;
        else if (tick_q) period_cnt <= period_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed bench for clk_div_ctrl. Stimulus queues the
// expected tick intervals and high-phase lengths; a negedge monitor pops and
// compares them as the divided clock runs.

module tb_clk_div_ctrl;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        enable;
    logic [15:0] cfg_div;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        out_clk;
    logic        out_tick;
    logic        busy;
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    logic [31:0] period_cnt;
`endif

    clk_div_ctrl #(.C_DIV_WIDTH(16), .C_DEFAULT_DIV(16)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .enable    (enable),
        .cfg_div   (cfg_div),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .out_clk   (out_clk),
        .out_tick  (out_tick),
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
        .period_cnt(period_cnt),
`endif
        .busy      (busy)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc++;

    int errors = 0;
    int checks = 0;
    int exp_tick[$];
    int exp_hi[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: interval from RUN entry / previous tick, and high-phase length
    logic mon_prev_clk  = 1'b0;
    logic mon_prev_busy = 1'b0;
    int   mon_mark      = 0;
    int   mon_rise      = 0;
    int   mon_ticks     = 0;

    always @(negedge aclk) begin
        if (aresetn !== 1'b1) begin
            mon_prev_clk  = 1'b0;
            mon_prev_busy = 1'b0;
            mon_ticks     = 0;
        end else begin
            if (busy && !mon_prev_busy) mon_mark = cyc;
            if (out_tick || (out_clk && !mon_prev_clk))
                chk("tick_align", int'(out_tick), int'(out_clk && !mon_prev_clk));
            if (out_tick) begin
                mon_ticks++;
                if (exp_tick.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tick_unexpected: got tick at cycle %0d expected none", cyc);
                end else begin
                    chk("tick_interval", cyc - mon_mark, exp_tick.pop_front());
                end
                mon_mark = cyc;
            end
            if (out_clk && !mon_prev_clk) mon_rise = cyc;
            if (!out_clk && mon_prev_clk) begin
                if (exp_hi.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL high_unexpected: got high phase %0d expected none", cyc - mon_rise);
                end else begin
                    chk("high_len", cyc - mon_rise, exp_hi.pop_front());
                end
            end
            mon_prev_clk  = out_clk;
            mon_prev_busy = busy;
        end
    end

    // Wait for n ticks; returns at the negedge where the last one was seen
    task automatic wait_ticks(input int n);
        int seen = 0;
        int t = 0;
        while (seen < n && t < 400) begin
            @(negedge aclk);
            t++;
            if (out_tick) seen++;
        end
        if (seen < n) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: got %0d ticks expected %0d", seen, n);
        end
    endtask

    // Wait for busy to drop; gap = cycles from out_clk fall to busy low
    task automatic wait_idle(output int gap);
        int t = 0;
        int fall = -1;
        gap = -1;
        while (t < 100) begin
            @(negedge aclk);
            t++;
            if (!out_clk && fall < 0) fall = cyc;
            if (!busy) begin
                gap = (fall < 0) ? -1 : cyc - fall;
                break;
            end
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=1 expected busy=0");
        end
    endtask

    task automatic cfg_write(input logic [15:0] d);
        @(negedge aclk);
        chk("cfg_ready_idle", int'(cfg_ready), 1);
        cfg_div   = d;
        cfg_valid = 1'b1;
        @(negedge aclk);
        cfg_valid = 1'b0;
        chk("idle_after_cfg", int'(busy), 0);
    endtask

    task automatic run_and_stop(input int n);
        int gap;
        enable = 1'b1;
        wait_ticks(n);
        enable = 1'b0;
        wait_idle(gap);
        chk("stop_gap", gap, 1);
        repeat (6) @(negedge aclk);
    endtask

    initial begin
        int gap;
        aresetn   = 1'b0;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = 16'd0;
        repeat (3) @(negedge aclk);
        chk("rst_out_clk",   int'(out_clk),   0);
        chk("rst_out_tick",  int'(out_tick),  0);
        chk("rst_busy",      int'(busy),      0);
        chk("rst_cfg_ready", int'(cfg_ready), 0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("post_rst_ready", int'(cfg_ready), 1);
        chk("post_rst_busy",  int'(busy),      0);

        // Default divide by 16
        exp_tick.push_back(8);  exp_tick.push_back(16); exp_tick.push_back(16);
        exp_hi.push_back(8);    exp_hi.push_back(8);    exp_hi.push_back(8);
        run_and_stop(3);

        // Odd divisor rounds down: 5 -> 4
        cfg_write(16'd5);
        exp_tick.push_back(2);  exp_tick.push_back(4);  exp_tick.push_back(4);
        exp_hi.push_back(2);    exp_hi.push_back(2);    exp_hi.push_back(2);
        run_and_stop(3);

        // 0 and 1 both become divide by 2
        cfg_write(16'd0);
        exp_tick.push_back(1);  exp_tick.push_back(2);  exp_tick.push_back(2);
        exp_hi.push_back(1);    exp_hi.push_back(1);    exp_hi.push_back(1);
        run_and_stop(3);
        cfg_write(16'd1);
        exp_tick.push_back(1);  exp_tick.push_back(2);
        exp_hi.push_back(1);    exp_hi.push_back(1);
        run_and_stop(2);

        // Divisor change 16 -> 4 in the middle of a high phase
        cfg_write(16'd16);
        exp_tick.push_back(8);  exp_tick.push_back(10); exp_tick.push_back(4); exp_tick.push_back(4);
        exp_hi.push_back(8);    exp_hi.push_back(2);    exp_hi.push_back(2);   exp_hi.push_back(2);
        enable = 1'b1;
        wait_ticks(1);
        repeat (3) @(negedge aclk);
        chk("ready_run", int'(cfg_ready), 1);
        cfg_div   = 16'd4;
        cfg_valid = 1'b1;
        @(negedge aclk);
        cfg_valid = 1'b0;
        chk("ready_pend", int'(cfg_ready), 0);
        for (int t = 0; t < 20 && out_clk; t++) @(negedge aclk);
        chk("ready_after_boundary", int'(cfg_ready), 1);
        wait_ticks(3);
        enable = 1'b0;
        wait_idle(gap);
        chk("stop_gap_pend", gap, 1);
        repeat (6) @(negedge aclk);

        // Divide by 8, stop right after a tick
        cfg_write(16'd8);
        exp_tick.push_back(4);  exp_tick.push_back(8);
        exp_hi.push_back(4);    exp_hi.push_back(4);
        run_and_stop(2);

        // Enable fall together with a cfg transfer: stop, then new divisor 4
        exp_tick.push_back(4);  exp_tick.push_back(2);  exp_tick.push_back(4);
        exp_hi.push_back(4);    exp_hi.push_back(2);    exp_hi.push_back(2);
        enable = 1'b1;
        wait_ticks(1);
        chk("ready_run_stop", int'(cfg_ready), 1);
        enable    = 1'b0;
        cfg_div   = 16'd4;
        cfg_valid = 1'b1;
        @(negedge aclk);
        cfg_valid = 1'b0;
        chk("stop_busy", int'(busy), 1);
        chk("stop_ready", int'(cfg_ready), 0);
        wait_idle(gap);
        chk("stop_gap_xfer", gap, 1);
        run_and_stop(2);

        // Reset during PEND with out_clk high
        cfg_write(16'd16);
        exp_tick.push_back(8);
        enable = 1'b1;
        wait_ticks(1);
        cfg_div   = 16'd4;
        cfg_valid = 1'b1;
        @(negedge aclk);
        cfg_valid = 1'b0;
        chk("pend_ready_pre_rst", int'(cfg_ready), 0);
        chk("pend_clk_pre_rst", int'(out_clk), 1);
        #2 aresetn = 1'b0;
        #1;
        chk("async_rst_clk",   int'(out_clk),   0);
        chk("async_rst_busy",  int'(busy),      0);
        chk("async_rst_ready", int'(cfg_ready), 0);
        chk("async_rst_tick",  int'(out_tick),  0);
        enable = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rerst_ready", int'(cfg_ready), 1);
        chk("rerst_busy",  int'(busy),      0);
        exp_tick.push_back(8);  exp_tick.push_back(16);
        exp_hi.push_back(8);    exp_hi.push_back(8);
        run_and_stop(2);

        repeat (20) @(negedge aclk);
        chk("tick_queue_empty", exp_tick.size(), 0);
        chk("high_queue_empty", exp_hi.size(), 0);
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
        chk("period_cnt", int'(period_cnt), mon_ticks);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1, "watchdog");
    end

endmodule
